// File: rtl/block_gen_rot_if.sv
// rtl/block_gen_rot_if.sv - control/status bundle between the game datapath and the piece source
//
// Signals:
//   spawn        master->slave  pulse: promote preview piece to active, draw a new preview
//   rot_cw       master->slave  pulse: rotate active piece 90 degrees clockwise
//   rot_ccw      master->slave  pulse: rotate active piece 90 degrees counter-clockwise
//   block_num    slave->master  active piece id
//   rot_state    slave->master  active rotation count mod 4
//   block_matrix slave->master  active 4x4 occupancy, row-major, bit15 = row0/col0
//   next_num     slave->master  preview piece id
//   busy         slave->master  preview still settling; spawn is ignored while high

interface block_gen_rot_if;
    logic        spawn;
    logic        rot_cw;
    logic        rot_ccw;
    logic [2:0]  block_num;
    logic [1:0]  rot_state;
    logic [15:0] block_matrix;
    logic [2:0]  next_num;
    logic        busy;

    modport master (
        output spawn, rot_cw, rot_ccw,
        input  block_num, rot_state, block_matrix, next_num, busy
    );

    modport slave (
        input  spawn, rot_cw, rot_ccw,
        output block_num, rot_state, block_matrix, next_num, busy
    );
endinterface

// File: rtl/block_gen_rot.sv
// rtl/block_gen_rot.sv - registered Tetris piece source and 90-degree matrix rotator
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   bus    block_gen_rot_if.slave: spawn/rot_cw/rot_ccw requests in,
//          block_num/rot_state/block_matrix/next_num/busy out (all registered)
//
// Parameters:
//   NUM_BLOCKS  number of distinct pieces (4..7)
//   LFSR_SEED   nonzero reset value of the 16-bit preview LFSR
//
// Optional feature macro: BAG_RAND_EN
//   defined   : bag randomiser, every NUM_BLOCKS consecutive previews hold each id once;
//               a taken candidate is walked forward one id per cycle with busy high
//   undefined : plain LFSR draw, busy tied low

module block_gen_rot #(
    parameter int          NUM_BLOCKS = 7,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic          clk,
    input  logic          reset,
    block_gen_rot_if.slave bus
);

    localparam logic [2:0] NB = 3'(NUM_BLOCKS);

    // Only the rot-0 shapes are stored; every other orientation is derived.
    function automatic logic [15:0] base_shape(input logic [2:0] id);
        logic [15:0] s;
        case (id)
            3'd0:    s = 16'b0010001000100010;
            3'd1:    s = 16'b0000011001100000;
            3'd2:    s = 16'b0000110001100000;
            3'd3:    s = 16'b0100110001000000;
            3'd4:    s = 16'b1000100010001100;
            3'd5:    s = 16'b0000011011000000;
            3'd6:    s = 16'b0100010011000000;
            default: s = 16'b0010001000100010;
        endcase
        return s;
    endfunction

    // Cell (r,c) lives at bit 15-(4r+c). CW: new[r][c] = old[3-c][r].
    function automatic logic [15:0] rotate_cw(input logic [15:0] m);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n[15 - (4 * r + c)] = m[15 - (4 * (3 - c) + r)];
            end
        end
        return n;
    endfunction

    // CCW: new[r][c] = old[c][3-r].
    function automatic logic [15:0] rotate_ccw(input logic [15:0] m);
        logic [15:0] n;
        n = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                n[15 - (4 * r + c)] = m[15 - (4 * c + (3 - r))];
            end
        end
        return n;
    endfunction

    logic [15:0] lfsr_q;
    logic [2:0]  draw;
    logic [2:0]  block_num_q;
    logic [1:0]  rot_state_q;
    logic [15:0] block_matrix_q;
    logic [2:0]  next_num_q;
    logic        busy_q;
    logic        spawn_go;
    logic        do_cw;
    logic        do_ccw;
    logic        next_load;
    logic [2:0]  next_val;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10), shifting left.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    // Out-of-range raw values fold back once; raw is at most 7 and NB at least 4.
    always_comb begin
        draw = lfsr_q[2:0];
        if (draw >= NB) begin
            draw = draw - NB;
        end
    end

    // Spawn has priority over any rotate; opposing rotates cancel.
    assign spawn_go = bus.spawn & ~busy_q;
    assign do_cw    = ~spawn_go & bus.rot_cw & ~bus.rot_ccw;
    assign do_ccw   = ~spawn_go & bus.rot_ccw & ~bus.rot_cw;

    always_ff @(posedge clk) begin
        if (reset) begin
            block_num_q    <= 3'd0;
            rot_state_q    <= 2'd0;
            block_matrix_q <= base_shape(3'd0);
        end else if (spawn_go) begin
            block_num_q    <= next_num_q;
            rot_state_q    <= 2'd0;
            block_matrix_q <= base_shape(next_num_q);
        end else if (do_cw) begin
            rot_state_q    <= rot_state_q + 2'd1;
            block_matrix_q <= rotate_cw(block_matrix_q);
        end else if (do_ccw) begin
            rot_state_q    <= rot_state_q - 2'd1;
            block_matrix_q <= rotate_ccw(block_matrix_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            next_num_q <= 3'd1;
        end else if (next_load) begin
            next_num_q <= next_val;
        end
    end

`ifdef BAG_RAND_EN
    typedef enum logic {
        ST_IDLE,
        ST_SEARCH
    } state_t;

    localparam logic [NUM_BLOCKS-1:0] MASK_ONE = {{(NUM_BLOCKS-1){1'b0}}, 1'b1};

    state_t                 state_q;
    state_t                 state_d;
    logic [2:0]             cand_q;
    logic [2:0]             cand_d;
    logic [NUM_BLOCKS-1:0]  mask_q;
    logic [NUM_BLOCKS-1:0]  mask_set;

    // Shift-based lookup keeps the 3-bit id legal for any mask width.
    function automatic logic is_used(input logic [NUM_BLOCKS-1:0] m, input logic [2:0] id);
        logic [NUM_BLOCKS-1:0] s;
        s = m >> id;
        return s[0];
    endfunction

    function automatic logic [2:0] wrap_inc(input logic [2:0] id);
        return (id == NB - 3'd1) ? 3'd0 : id + 3'd1;
    endfunction

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        next_load = 1'b0;
        next_val  = cand_q;
        case (state_q)
            ST_IDLE: begin
                if (spawn_go) begin
                    if (!is_used(mask_q, draw)) begin
                        next_load = 1'b1;
                        next_val  = draw;
                    end else begin
                        // First probe of the walk happens in ST_SEARCH next cycle.
                        state_d = ST_SEARCH;
                        cand_d  = wrap_inc(draw);
                    end
                end
            end
            ST_SEARCH: begin
                if (!is_used(mask_q, cand_q)) begin
                    next_load = 1'b1;
                    next_val  = cand_q;
                    state_d   = ST_IDLE;
                end else begin
                    cand_d = wrap_inc(cand_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mask_set = mask_q | (MASK_ONE << next_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cand_q  <= 3'd0;
            mask_q  <= MASK_ONE << 1;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            if (next_load) begin
                // A full bag restarts holding only the id just handed out.
                mask_q <= (&mask_set) ? (MASK_ONE << next_val) : mask_set;
            end
        end
    end

    assign busy_q = (state_q == ST_SEARCH);
`else
    assign busy_q    = 1'b0;
    assign next_load = spawn_go;
    assign next_val  = draw;
`endif

    assign bus.block_num    = block_num_q;
    assign bus.rot_state    = rot_state_q;
    assign bus.block_matrix = block_matrix_q;
    assign bus.next_num     = next_num_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_block_gen_rot.sv
// tb/tb_block_gen_rot.sv - self-checking bench for block_gen_rot

module tb_block_gen_rot;

    localparam int          NB   = 7;
    localparam logic [15:0] SEED = 16'hACE1;

    logic clk;
    logic reset;

    block_gen_rot_if bus ();

    block_gen_rot #(
        .NUM_BLOCKS (NB),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_fail;

    logic [15:0] base_tbl [7];

    int          m_blk;
    int          m_rot;
    logic [15:0] m_mat;
    int          m_next;
    bit          m_busy;
    int          m_cd;
    int          m_pend;
    logic [15:0] m_lfsr;
    bit [6:0]    m_mask;

    typedef struct {
        bit          sp;
        bit          cw;
        bit          ccw;
        int          e_blk;
        int          e_rot;
        logic [15:0] e_mat;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        int v;
        int fb;
        v  = int'(x);
        fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
        return 16'(((v << 1) | fb) & 16'hFFFF);
    endfunction

    // Grid rotation straight from the cell equations.
    function automatic logic [15:0] mrot(input logic [15:0] m, input bit cw);
        bit g [4][4];
        bit h [4][4];
        logic [15:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                g[r][c] = m[15 - 4 * r - c];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                h[r][c] = cw ? g[3 - c][r] : g[c][3 - r];
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[15 - 4 * r - c] = h[r][c];
        return o;
    endfunction

    task automatic m_commit(input int id);
        bit full;
        m_next     = id;
        m_mask[id] = 1'b1;
        full = 1'b1;
        for (int i = 0; i < NB; i++) if (!m_mask[i]) full = 1'b0;
        if (full) begin
            m_mask     = '0;
            m_mask[id] = 1'b1;
        end
    endtask

    // One clock edge with the given inputs; the reference model advances alongside.
    task automatic step(input bit rst, input bit sp, input bit cw, input bit ccw);
        int draw;
        int cand;
        int k;
        bit go;
        reset       = rst;
        bus.spawn   = sp;
        bus.rot_cw  = cw;
        bus.rot_ccw = ccw;
        @(posedge clk);
        if (rst) begin
            m_blk     = 0;
            m_rot     = 0;
            m_mat     = base_tbl[0];
            m_next    = 1;
            m_busy    = 0;
            m_cd      = 0;
            m_pend    = 0;
            m_lfsr    = SEED;
            m_mask    = '0;
            m_mask[1] = 1'b1;
        end else begin
            draw = int'(m_lfsr) % 8;
            if (draw >= NB) draw -= NB;
            m_lfsr = lfsr_adv(m_lfsr);
            go = sp && !m_busy;
            if (m_busy) begin
                m_cd--;
                if (m_cd == 0) begin
                    m_busy = 0;
                    m_commit(m_pend);
                end
            end
            if (go) begin
                m_blk = m_next;
                m_rot = 0;
                m_mat = base_tbl[m_next];
`ifdef BAG_RAND_EN
                cand = draw;
                k    = 0;
                while (m_mask[cand]) begin
                    cand = (cand + 1) % NB;
                    k++;
                end
                if (k == 0) m_commit(cand);
                else begin
                    m_busy = 1;
                    m_cd   = k;
                    m_pend = cand;
                end
`else
                cand   = draw;
                k      = 0;
                m_next = cand + k;
`endif
            end else if (cw && !ccw) begin
                m_mat = mrot(m_mat, 1'b1);
                m_rot = (m_rot + 1) % 4;
            end else if (ccw && !cw) begin
                m_mat = mrot(m_mat, 1'b0);
                m_rot = (m_rot + 3) % 4;
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".block_num"},    int'(bus.block_num),    m_blk);
        chk({tag, ".rot_state"},    int'(bus.rot_state),    m_rot);
        chk({tag, ".block_matrix"}, int'(bus.block_matrix), int'(m_mat));
        chk({tag, ".next_num"},     int'(bus.next_num),     m_next);
        chk({tag, ".busy"},         int'(bus.busy),         int'(m_busy));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".block_num"},    int'(bus.block_num),    0);
        chk({tag, ".rot_state"},    int'(bus.rot_state),    0);
        chk({tag, ".block_matrix"}, int'(bus.block_matrix), 16'h2222);
        chk({tag, ".next_num"},     int'(bus.next_num),     1);
        chk({tag, ".busy"},         int'(bus.busy),         0);
    endtask

    initial begin
        int  found;
        int  blen;
        int  seq[$];
        bit  rr;
        bit  rs;
        bit  rc;
        bit  ra;
        bit [6:0] seen;

        n_cmp  = 0;
        n_fail = 0;
        base_tbl[0] = 16'b0010001000100010;
        base_tbl[1] = 16'b0000011001100000;
        base_tbl[2] = 16'b0000110001100000;
        base_tbl[3] = 16'b0100110001000000;
        base_tbl[4] = 16'b1000100010001100;
        base_tbl[5] = 16'b0000011011000000;
        base_tbl[6] = 16'b0100010011000000;

        // Line piece from reset, then the O piece after the first spawn.
        vt[0] = '{0, 1, 0, 0, 1, 16'h00F0};
        vt[1] = '{0, 1, 0, 0, 2, 16'h4444};
        vt[2] = '{0, 1, 0, 0, 3, 16'h0F00};
        vt[3] = '{0, 1, 0, 0, 0, 16'h2222};
        vt[4] = '{0, 0, 1, 0, 3, 16'h0F00};
        vt[5] = '{0, 1, 1, 0, 3, 16'h0F00};
        vt[6] = '{0, 0, 0, 0, 3, 16'h0F00};
        vt[7] = '{0, 0, 1, 0, 2, 16'h4444};
        vt[8] = '{1, 1, 0, 1, 0, 16'h0660};
        vt[9] = '{0, 1, 0, 1, 1, 16'h0660};

        reset       = 1'b1;
        bus.spawn   = 1'b0;
        bus.rot_cw  = 1'b0;
        bus.rot_ccw = 1'b0;
        #2;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check_reset_vals("reset");

        for (int i = 0; i < 10; i++) begin
            step(0, vt[i].sp, vt[i].cw, vt[i].ccw);
            chk($sformatf("vec%0d.block_num", i),    int'(bus.block_num),    vt[i].e_blk);
            chk($sformatf("vec%0d.rot_state", i),    int'(bus.rot_state),    vt[i].e_rot);
            chk($sformatf("vec%0d.block_matrix", i), int'(bus.block_matrix), int'(vt[i].e_mat));
        end
        check_model("after_table");

        // T piece: walk the preview until it offers id 3, then spawn it.
        found = 0;
        for (int i = 0; i < 400 && found == 0; i++) begin
            if (m_next == 3 && !m_busy) found = 1;
            else step(0, !m_busy, 0, 0);
        end
        chk("t_piece_reachable", found, 1);
        step(0, 1, 0, 0);
        chk("t.block_num", int'(bus.block_num), 3);
        chk("t.matrix0", int'(bus.block_matrix), 16'h4C40);
        step(0, 0, 1, 0);
        chk("t.cw1_matrix", int'(bus.block_matrix), 16'h2700);
        chk("t.cw1_rot", int'(bus.rot_state), 1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        chk("t.cw4_matrix", int'(bus.block_matrix), 16'h4C40);
        chk("t.cw4_rot", int'(bus.rot_state), 0);
        step(0, 0, 0, 1);
        chk("t.ccw_matrix", int'(bus.block_matrix), 16'h00E4);
        chk("t.ccw_rot", int'(bus.rot_state), 3);
        step(0, 1, 1, 0);
        chk("spawn_rot.rot", int'(bus.rot_state), 0);
        check_model("spawn_rot");

        // Reset coinciding with a rotate request must swallow the rotation.
        step(0, 0, 1, 0);
        step(1, 0, 1, 0);
        check_reset_vals("rst_rot");
        step(0, 0, 0, 0);
        chk("rst_rot.after", int'(bus.block_matrix), 16'h2222);

        // Random traffic against the reference model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rr = ($urandom_range(0, 99) < 2);
            rs = ($urandom_range(0, 2) == 0);
            rc = ($urandom_range(0, 3) == 0);
            ra = ($urandom_range(0, 3) == 0);
            step(rr, rs, rc, ra);
            check_model($sformatf("rand%0d", i));
        end

`ifdef BAG_RAND_EN
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        seq.delete();
        seq.push_back(int'(bus.next_num));
        for (int s = 0; s < 70; s++) begin
            step(0, 1, 0, 0);
            blen = 0;
            while (bus.busy && blen < 10) begin
                step(0, 0, 0, 0);
                blen++;
            end
            n_cmp++;
            if (blen > 6) begin
                n_fail++;
                $display("FAIL bag.busy_len: got %0d cycles, expected at most 6", blen);
            end
            check_model($sformatf("bag%0d", s));
            seq.push_back(int'(bus.next_num));
        end
        for (int g = 0; g < 10; g++) begin
            seen = '0;
            for (int j = 0; j < 7; j++) seen[seq[g * 7 + j]] = 1'b1;
            chk($sformatf("bag.perm%0d", g), int'(seen), 7'h7F);
        end
`endif

        step(0, 0, 0, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
